// File: rtl/mhq_pkg.sv
// Shared types and helpers for the miss handling queue.
// LSU op encodings, entry states and the op-size byte-enable decode.
package mhq_pkg;

   localparam int PCYN_LSU_FUNC_WIDTH = 4;

   localparam logic [3:0] PCYN_LSU_FUNC_LB  = 4'b0000;
   localparam logic [3:0] PCYN_LSU_FUNC_LH  = 4'b0001;
   localparam logic [3:0] PCYN_LSU_FUNC_LW  = 4'b0010;
   localparam logic [3:0] PCYN_LSU_FUNC_LBU = 4'b0011;
   localparam logic [3:0] PCYN_LSU_FUNC_LHU = 4'b0100;
   localparam logic [3:0] PCYN_LSU_FUNC_SB  = 4'b0101;
   localparam logic [3:0] PCYN_LSU_FUNC_SH  = 4'b0110;
   localparam logic [3:0] PCYN_LSU_FUNC_SW  = 4'b0111;

   typedef enum logic [1:0] {
      MHQ_INVALID,
      MHQ_PENDING,
      MHQ_ISSUED,
      MHQ_COMPLETE
   } mhq_state_t;

   function automatic logic [3:0] lsu_byte_en(
      input logic [PCYN_LSU_FUNC_WIDTH-1:0] func
   );
      logic [3:0] be;
      case (func)
         PCYN_LSU_FUNC_SB,
         PCYN_LSU_FUNC_LB,
         PCYN_LSU_FUNC_LBU: be = 4'b0001;
         PCYN_LSU_FUNC_SH,
         PCYN_LSU_FUNC_LH,
         PCYN_LSU_FUNC_LHU: be = 4'b0011;
         default:           be = 4'b1111;
      endcase
      return be;
   endfunction

endpackage

// File: rtl/mhq_if.sv
// LSU lookup/fill and memory request/response bundle of the MHQ.
// slave is the queue's view; master is the LSU/memory side.
interface mhq_if import mhq_pkg::*; #(
   parameter int AW = 32,
   parameter int DW = 32,
   parameter int LW = 256,
   parameter int IW = 2
);
   logic                           i_lookup_valid;
   logic                           i_lookup_dc_hit;
   logic [AW-1:0]                  i_lookup_addr;
   logic [PCYN_LSU_FUNC_WIDTH-1:0] i_lookup_lsu_func;
   logic [DW-1:0]                  i_lookup_data;
   logic                           i_lookup_we;
   logic                           o_lookup_retry;
   logic [IW-1:0]                  o_lookup_tag;
   logic                           o_fill_en;
   logic [AW-1:0]                  o_fill_addr;
   logic [IW-1:0]                  o_fill_tag;
   logic [LW-1:0]                  o_fill_data;
   logic                           o_fill_dirty;
   logic                           o_mem_req_en;
   logic [AW-1:0]                  o_mem_req_addr;
   logic                           i_mem_req_ack;
   logic                           i_mem_rsp_en;
   logic [LW-1:0]                  i_mem_rsp_data;

   modport slave (
      input  i_lookup_valid, i_lookup_dc_hit, i_lookup_addr,
      input  i_lookup_lsu_func, i_lookup_data, i_lookup_we,
      output o_lookup_retry, o_lookup_tag,
      output o_fill_en, o_fill_addr, o_fill_tag,
      output o_fill_data, o_fill_dirty,
      output o_mem_req_en, o_mem_req_addr,
      input  i_mem_req_ack, i_mem_rsp_en, i_mem_rsp_data
   );

   modport master (
      output i_lookup_valid, i_lookup_dc_hit, i_lookup_addr,
      output i_lookup_lsu_func, i_lookup_data, i_lookup_we,
      input  o_lookup_retry, o_lookup_tag,
      input  o_fill_en, o_fill_addr, o_fill_tag,
      input  o_fill_data, o_fill_dirty,
      input  o_mem_req_en, o_mem_req_addr,
      output i_mem_req_ack, i_mem_rsp_en, i_mem_rsp_data
   );
endinterface

// File: rtl/mhq_entry.sv
// One miss handling queue entry: state, line address, line buffer,
// store byte mask and dirty flag, with response/store merging.
module mhq_entry import mhq_pkg::*; #(
   parameter int AW   = 32,
   parameter int LINE = 32,
   parameter int LW   = 8*LINE
) (
   input  logic            clk,
   input  logic            n_rst,
   input  logic            alloc,
   input  logic [AW-1:0]   line_addr,
   input  logic            wr_en,
   input  logic [LINE-1:0] wr_mask,
   input  logic [LW-1:0]   wr_data,
   input  logic            ack,
   input  logic            rsp,
   input  logic [LW-1:0]   rsp_data,
   input  logic            fill,
   output mhq_state_t      state,
   output logic [AW-1:0]   addr,
   output logic [LW-1:0]   data,
   output logic            dirty
);

   logic [LINE-1:0] mask;
   logic [LINE-1:0] mask_nxt;
   logic [LW-1:0]   data_nxt;
   logic [LW-1:0]   wr_bits;
   logic [LW-1:0]   own_bits;

   // response fills only unwritten bytes, then a same-cycle store wins
   always_comb begin
      for (int i = 0; i < LINE; i++) begin
         wr_bits[8*i +: 8]  = {8{wr_mask[i]}};
         own_bits[8*i +: 8] = {8{mask[i]}};
      end
      data_nxt = alloc ? '0 : data;
      mask_nxt = alloc ? '0 : mask;
      if (rsp) begin
         data_nxt = (rsp_data & ~own_bits) | (data & own_bits);
      end
      if (wr_en) begin
         data_nxt = (data_nxt & ~wr_bits) | (wr_data & wr_bits);
         mask_nxt = mask_nxt | wr_mask;
      end
   end

   // entry registers and lifecycle state
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state <= MHQ_INVALID;
         addr  <= '0;
         data  <= '0;
         mask  <= '0;
         dirty <= 1'b0;
      end else begin
         data <= data_nxt;
         mask <= mask_nxt;
         if (alloc) begin
            addr  <= line_addr;
            dirty <= wr_en;
         end else if (wr_en) begin
            dirty <= 1'b1;
         end
         unique case (1'b1)
            alloc:   state <= MHQ_PENDING;
            ack:     state <= MHQ_ISSUED;
            rsp:     state <= MHQ_COMPLETE;
            fill:    state <= MHQ_INVALID;
            default: state <= state;
         endcase
      end
   end

endmodule

// File: rtl/mhq.sv
// Miss handling queue: allocates/merges D$ misses, issues line reads
// in order, merges store bytes into responses and fills the D$.
module mhq import mhq_pkg::*; #(
   parameter int OPTN_DATA_WIDTH    = 32,
   parameter int OPTN_ADDR_WIDTH    = 32,
   parameter int OPTN_DC_LINE_SIZE  = 32,
   parameter int OPTN_MHQ_DEPTH     = 4,
   parameter int OPTN_MHQ_IDX_WIDTH = 2
) (
   input logic  clk,
   input logic  n_rst,
   mhq_if.slave io
);

   localparam int AW    = OPTN_ADDR_WIDTH;
   localparam int DW    = OPTN_DATA_WIDTH;
   localparam int LINE  = OPTN_DC_LINE_SIZE;
   localparam int LW    = 8*LINE;
   localparam int OW    = $clog2(LINE);
   localparam int DEPTH = OPTN_MHQ_DEPTH;
   localparam int IW    = OPTN_MHQ_IDX_WIDTH;

   mhq_state_t    st     [DEPTH];
   logic [AW-1:0] e_addr [DEPTH];
   logic [LW-1:0] e_data [DEPTH];
   logic          e_dirty[DEPTH];

   logic [IW-1:0]   tail;
   logic [IW-1:0]   issue;
   logic [IW-1:0]   rsp_ptr;
   logic [IW-1:0]   head;
   logic [IW:0]     count;

   logic [AW-1:0]   line_addr;
   logic [OW-1:0]   ofs;
   logic [LINE-1:0] wr_mask;
   logic [LW-1:0]   wr_data;
   logic            hit;
   logic [IW-1:0]   hit_idx;
   logic            open;
   logic            full;
   logic            lk;
   logic            do_merge;
   logic            do_alloc;
   logic            do_retry;
   logic            fill_go;

   assign line_addr = {io.i_lookup_addr[AW-1:OW], {OW{1'b0}}};
   assign ofs       = io.i_lookup_addr[OW-1:0];
   assign wr_mask   = {{(LINE-4){1'b0}},
                       lsu_byte_en(io.i_lookup_lsu_func)} << ofs;
   assign wr_data   = {{(LW-DW){1'b0}}, io.i_lookup_data}
                      << {ofs, 3'b000};

   // find a live entry holding the looked-up line
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (st[i] != MHQ_INVALID && e_addr[i] == line_addr) begin
            hit     = 1'b1;
            hit_idx = IW'(i);
         end
      end
   end

   assign open     = (st[hit_idx] == MHQ_PENDING) ||
                     (st[hit_idx] == MHQ_ISSUED);
   assign full     = (count == (IW+1)'(DEPTH));
   assign lk       = io.i_lookup_valid && !io.i_lookup_dc_hit;
   assign do_merge = lk && hit && open;
   assign do_alloc = lk && !hit && !full;
   assign do_retry = lk && ((hit && !open) || (!hit && full));
   assign fill_go  = (st[head] == MHQ_COMPLETE);

   assign io.o_mem_req_en   = (st[issue] == MHQ_PENDING);
   assign io.o_mem_req_addr = e_addr[issue];

   for (genvar g = 0; g < DEPTH; g++) begin : g_ent
      mhq_entry #(
         .AW   (AW),
         .LINE (LINE),
         .LW   (LW)
      ) u_ent (
         .clk       (clk),
         .n_rst     (n_rst),
         .alloc     (do_alloc && tail == IW'(g)),
         .line_addr (line_addr),
         .wr_en     (io.i_lookup_we &&
                     ((do_alloc && tail == IW'(g)) ||
                      (do_merge && hit_idx == IW'(g)))),
         .wr_mask   (wr_mask),
         .wr_data   (wr_data),
         .ack       (io.i_mem_req_ack && issue == IW'(g)),
         .rsp       (io.i_mem_rsp_en && rsp_ptr == IW'(g)),
         .rsp_data  (io.i_mem_rsp_data),
         .fill      (fill_go && head == IW'(g)),
         .state     (st[g]),
         .addr      (e_addr[g]),
         .data      (e_data[g]),
         .dirty     (e_dirty[g])
      );
   end

   // queue pointers and occupancy
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         tail    <= '0;
         issue   <= '0;
         rsp_ptr <= '0;
         head    <= '0;
         count   <= '0;
      end else begin
         if (do_alloc)         tail    <= tail + 1'b1;
         if (io.i_mem_req_ack) issue   <= issue + 1'b1;
         if (io.i_mem_rsp_en)  rsp_ptr <= rsp_ptr + 1'b1;
         if (fill_go)          head    <= head + 1'b1;
         count <= count + (IW+1)'(do_alloc) - (IW+1)'(fill_go);
      end
   end

   // registered lookup result and fill outputs
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         io.o_lookup_retry <= 1'b0;
         io.o_lookup_tag   <= '0;
         io.o_fill_en      <= 1'b0;
         io.o_fill_addr    <= '0;
         io.o_fill_tag     <= '0;
         io.o_fill_data    <= '0;
         io.o_fill_dirty   <= 1'b0;
      end else begin
         io.o_lookup_retry <= do_retry;
         io.o_lookup_tag   <= do_merge ? hit_idx : tail;
         io.o_fill_en      <= fill_go;
         if (fill_go) begin
            io.o_fill_addr  <= e_addr[head];
            io.o_fill_tag   <= head;
            io.o_fill_data  <= e_data[head];
            io.o_fill_dirty <= e_dirty[head];
         end
      end
   end

   a_rsp_issued: assert property (@(posedge clk) disable iff (!n_rst)
      io.i_mem_rsp_en |-> st[rsp_ptr] == MHQ_ISSUED);

   a_ack_req: assert property (@(posedge clk) disable iff (!n_rst)
      io.i_mem_req_ack |-> io.o_mem_req_en);

endmodule

// File: tb/tb_mhq.sv
// Directed-vector bench for the miss handling queue.
// One task per scenario, each with its own inline comparisons.
module tb_mhq;
   import mhq_pkg::*;

   logic clk = 1'b0;
   logic n_rst = 1'b0;
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   mhq_if #(.AW(32), .DW(32), .LW(256), .IW(2)) io ();

   mhq u_dut (
      .clk   (clk),
      .n_rst (n_rst),
      .io    (io)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      io.i_lookup_valid    = 1'b0;
      io.i_lookup_dc_hit   = 1'b0;
      io.i_lookup_addr     = '0;
      io.i_lookup_lsu_func = PCYN_LSU_FUNC_LW;
      io.i_lookup_data     = '0;
      io.i_lookup_we       = 1'b0;
      io.i_mem_req_ack     = 1'b0;
      io.i_mem_rsp_en      = 1'b0;
      io.i_mem_rsp_data    = '0;
   endtask

   task automatic do_reset();
      idle();
      n_rst = 1'b0;
      repeat (2) tick();
      n_rst = 1'b1;
      tick();
   endtask

   task automatic lk(input logic [31:0] a, input logic [3:0] f,
                     input logic w, input logic [31:0] d,
                     input logic h);
      io.i_lookup_valid    = 1'b1;
      io.i_lookup_dc_hit   = h;
      io.i_lookup_addr     = a;
      io.i_lookup_lsu_func = f;
      io.i_lookup_we       = w;
      io.i_lookup_data     = d;
      tick();
      io.i_lookup_valid = 1'b0;
      io.i_lookup_we    = 1'b0;
   endtask

   task automatic ack1();
      io.i_mem_req_ack = 1'b1;
      tick();
      io.i_mem_req_ack = 1'b0;
   endtask

   task automatic rsp1(input logic [255:0] d);
      io.i_mem_rsp_en   = 1'b1;
      io.i_mem_rsp_data = d;
      tick();
      io.i_mem_rsp_en = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++;
      if (io.o_lookup_retry !== 1'b0 || io.o_lookup_tag !== 2'd0) begin
         n_bad++;
         $display("FAIL rst_lookup: got %b/%0d want 0/0",
                  io.o_lookup_retry, io.o_lookup_tag);
      end
      n_cmp++;
      if (io.o_fill_en !== 1'b0 || io.o_mem_req_en !== 1'b0) begin
         n_bad++;
         $display("FAIL rst_en: got fill %b req %b want 0 0",
                  io.o_fill_en, io.o_mem_req_en);
      end
      n_cmp++;
      if (io.o_fill_addr !== 32'h0 || io.o_mem_req_addr !== 32'h0 ||
          io.o_fill_data !== 256'h0) begin
         n_bad++;
         $display("FAIL rst_addr: got %h %h want 0 0",
                  io.o_fill_addr, io.o_mem_req_addr);
      end
   endtask

   task automatic test_load_miss();
      logic [255:0] exp;
      exp = {32{8'hA5}};
      do_reset();
      lk(32'h1000, PCYN_LSU_FUNC_LW, 1'b0, 32'h0, 1'b0);
      n_cmp++;
      if (io.o_lookup_retry !== 1'b0 || io.o_lookup_tag !== 2'd0) begin
         n_bad++;
         $display("FAIL t1_lookup: got %b/%0d want 0/0",
                  io.o_lookup_retry, io.o_lookup_tag);
      end
      n_cmp++;
      if (io.o_mem_req_en !== 1'b1 || io.o_mem_req_addr !== 32'h1000) begin
         n_bad++;
         $display("FAIL t1_req: got %b %h want 1 00001000",
                  io.o_mem_req_en, io.o_mem_req_addr);
      end
      ack1();
      n_cmp++;
      if (io.o_mem_req_en !== 1'b0) begin
         n_bad++;
         $display("FAIL t1_req_drop: got %b want 0", io.o_mem_req_en);
      end
      rsp1(exp);
      n_cmp++;
      if (io.o_fill_en !== 1'b0) begin
         n_bad++;
         $display("FAIL t1_fill_early: got %b want 0", io.o_fill_en);
      end
      tick();
      n_cmp++;
      if (io.o_fill_en !== 1'b1 || io.o_fill_addr !== 32'h1000 ||
          io.o_fill_tag !== 2'd0 || io.o_fill_dirty !== 1'b0) begin
         n_bad++;
         $display("FAIL t1_fill: got %b %h %0d %b want 1 00001000 0 0",
                  io.o_fill_en, io.o_fill_addr, io.o_fill_tag,
                  io.o_fill_dirty);
      end
      n_cmp++;
      if (io.o_fill_data !== exp) begin
         n_bad++;
         $display("FAIL t1_data: got %h want %h", io.o_fill_data, exp);
      end
      tick();
      n_cmp++;
      if (io.o_fill_en !== 1'b0) begin
         n_bad++;
         $display("FAIL t1_fill_once: got %b want 0", io.o_fill_en);
      end
   endtask

   task automatic test_store_merge();
      logic [255:0] exp;
      exp = '0;
      exp[63:32] = 32'hDEADBEEF;
      do_reset();
      lk(32'h1004, PCYN_LSU_FUNC_SW, 1'b1, 32'hDEADBEEF, 1'b0);
      n_cmp++;
      if (io.o_lookup_retry !== 1'b0 || io.o_lookup_tag !== 2'd0) begin
         n_bad++;
         $display("FAIL t2_sw: got %b/%0d want 0/0",
                  io.o_lookup_retry, io.o_lookup_tag);
      end
      lk(32'h101F, PCYN_LSU_FUNC_LB, 1'b0, 32'h0, 1'b0);
      n_cmp++;
      if (io.o_lookup_retry !== 1'b0 || io.o_lookup_tag !== 2'd0) begin
         n_bad++;
         $display("FAIL t2_lb: got %b/%0d want 0/0",
                  io.o_lookup_retry, io.o_lookup_tag);
      end
      ack1();
      n_cmp++;
      if (io.o_mem_req_en !== 1'b0) begin
         n_bad++;
         $display("FAIL t2_one_req: got %b want 0", io.o_mem_req_en);
      end
      rsp1('0);
      tick();
      n_cmp++;
      if (io.o_fill_en !== 1'b1 || io.o_fill_dirty !== 1'b1 ||
          io.o_fill_data !== exp) begin
         n_bad++;
         $display("FAIL t2_fill: got %b %b %h want 1 1 %h",
                  io.o_fill_en, io.o_fill_dirty, io.o_fill_data, exp);
      end
   endtask

   task automatic test_full();
      do_reset();
      for (int i = 0; i < 4; i++) begin
         lk(32'(i*32), PCYN_LSU_FUNC_LW, 1'b0, 32'h0, 1'b0);
         n_cmp++;
         if (io.o_lookup_retry !== 1'b0 || io.o_lookup_tag !== 2'(i)) begin
            n_bad++;
            $display("FAIL t3_alloc%0d: got %b/%0d want 0/%0d", i,
                     io.o_lookup_retry, io.o_lookup_tag, i);
         end
      end
      lk(32'h80, PCYN_LSU_FUNC_LW, 1'b0, 32'h0, 1'b0);
      n_cmp++;
      if (io.o_lookup_retry !== 1'b1) begin
         n_bad++;
         $display("FAIL t3_full: got %b want 1", io.o_lookup_retry);
      end
      lk(32'hA0, PCYN_LSU_FUNC_LW, 1'b0, 32'h0, 1'b1);
      n_cmp++;
      if (io.o_lookup_retry !== 1'b0) begin
         n_bad++;
         $display("FAIL t3_dc_hit: got %b want 0", io.o_lookup_retry);
      end
      io.i_mem_req_ack = 1'b1;
      repeat (4) tick();
      io.i_mem_req_ack = 1'b0;
      n_cmp++;
      if (io.o_mem_req_en !== 1'b0) begin
         n_bad++;
         $display("FAIL t3_all_issued: got %b want 0", io.o_mem_req_en);
      end
      rsp1({32{8'h3C}});
      lk(32'h80, PCYN_LSU_FUNC_LW, 1'b0, 32'h0, 1'b0);
      n_cmp++;
      if (io.o_lookup_retry !== 1'b1 || io.o_fill_en !== 1'b1 ||
          io.o_fill_addr !== 32'h0) begin
         n_bad++;
         $display("FAIL t3_fill_full: got %b %b %h want 1 1 0",
                  io.o_lookup_retry, io.o_fill_en, io.o_fill_addr);
      end
      lk(32'h80, PCYN_LSU_FUNC_LW, 1'b0, 32'h0, 1'b0);
      n_cmp++;
      if (io.o_lookup_retry !== 1'b0 || io.o_lookup_tag !== 2'd0) begin
         n_bad++;
         $display("FAIL t3_realloc: got %b/%0d want 0/0",
                  io.o_lookup_retry, io.o_lookup_tag);
      end
   endtask

   task automatic test_complete_and_rsp_merge();
      logic [255:0] exp;
      exp = '1;
      exp[95:64] = 32'h12345678;
      do_reset();
      lk(32'h2000, PCYN_LSU_FUNC_LW, 1'b0, 32'h0, 1'b0);
      ack1();
      rsp1({32{8'h11}});
      lk(32'h2004, PCYN_LSU_FUNC_LW, 1'b0, 32'h0, 1'b0);
      n_cmp++;
      if (io.o_lookup_retry !== 1'b1 || io.o_fill_en !== 1'b1) begin
         n_bad++;
         $display("FAIL t4_complete: got retry %b fill %b want 1 1",
                  io.o_lookup_retry, io.o_fill_en);
      end
      lk(32'h3000, PCYN_LSU_FUNC_LW, 1'b0, 32'h0, 1'b0);
      n_cmp++;
      if (io.o_lookup_tag !== 2'd1) begin
         n_bad++;
         $display("FAIL t4_tag: got %0d want 1", io.o_lookup_tag);
      end
      ack1();
      io.i_mem_rsp_en   = 1'b1;
      io.i_mem_rsp_data = '1;
      lk(32'h3008, PCYN_LSU_FUNC_SW, 1'b1, 32'h12345678, 1'b0);
      io.i_mem_rsp_en = 1'b0;
      n_cmp++;
      if (io.o_lookup_retry !== 1'b0 || io.o_lookup_tag !== 2'd1) begin
         n_bad++;
         $display("FAIL t4_merge: got %b/%0d want 0/1",
                  io.o_lookup_retry, io.o_lookup_tag);
      end
      tick();
      n_cmp++;
      if (io.o_fill_en !== 1'b1 || io.o_fill_tag !== 2'd1 ||
          io.o_fill_dirty !== 1'b1 || io.o_fill_data !== exp) begin
         n_bad++;
         $display("FAIL t4_fill: got %b %0d %b %h want 1 1 1 %h",
                  io.o_fill_en, io.o_fill_tag, io.o_fill_dirty,
                  io.o_fill_data, exp);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0]  a;
      logic [255:0] d;
      do_reset();
      for (int i = 0; i < 6; i++) begin
         a = 32'h4000 + 32'(i*32);
         d = {32{8'(i + 1)}};
         lk(a, PCYN_LSU_FUNC_LW, 1'b0, 32'h0, 1'b0);
         n_cmp++;
         if (io.o_lookup_retry !== 1'b0 || io.o_lookup_tag !== 2'(i % 4)) begin
            n_bad++;
            $display("FAIL t5_tag%0d: got %b/%0d want 0/%0d", i,
                     io.o_lookup_retry, io.o_lookup_tag, i % 4);
         end
         ack1();
         rsp1(d);
         tick();
         n_cmp++;
         if (io.o_fill_en !== 1'b1 || io.o_fill_addr !== a ||
             io.o_fill_tag !== 2'(i % 4) || io.o_fill_data !== d) begin
            n_bad++;
            $display("FAIL t5_fill%0d: got %b %h %0d want 1 %h %0d", i,
                     io.o_fill_en, io.o_fill_addr, io.o_fill_tag,
                     a, i % 4);
         end
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      lk(32'h6000, PCYN_LSU_FUNC_LW, 1'b0, 32'h0, 1'b0);
      ack1();
      rsp1({32{8'hA5}});
      tick();
      lk(32'h5000, PCYN_LSU_FUNC_LW, 1'b0, 32'h0, 1'b0);
      lk(32'h5020, PCYN_LSU_FUNC_LW, 1'b0, 32'h0, 1'b0);
      ack1();
      ack1();
      lk(32'h5040, PCYN_LSU_FUNC_LW, 1'b0, 32'h0, 1'b0);
      n_cmp++;
      if (io.o_mem_req_en !== 1'b1 || io.o_lookup_tag !== 2'd3) begin
         n_bad++;
         $display("FAIL t6_pre: got %b %0d want 1 3",
                  io.o_mem_req_en, io.o_lookup_tag);
      end
      #2;
      n_rst = 1'b0;
      #1;
      n_cmp++;
      if (io.o_lookup_tag !== 2'd0 || io.o_mem_req_en !== 1'b0 ||
          io.o_mem_req_addr !== 32'h0 || io.o_fill_addr !== 32'h0 ||
          io.o_fill_data !== 256'h0 || io.o_fill_en !== 1'b0 ||
          io.o_lookup_retry !== 1'b0) begin
         n_bad++;
         $display("FAIL t6_async: got tag %0d req %b %h fill %b %h",
                  io.o_lookup_tag, io.o_mem_req_en, io.o_mem_req_addr,
                  io.o_fill_en, io.o_fill_addr);
      end
      tick();
      n_rst = 1'b1;
      tick();
      lk(32'h7000, PCYN_LSU_FUNC_LW, 1'b0, 32'h0, 1'b0);
      n_cmp++;
      if (io.o_lookup_retry !== 1'b0 || io.o_lookup_tag !== 2'd0 ||
          io.o_mem_req_addr !== 32'h7000) begin
         n_bad++;
         $display("FAIL t6_post: got %b/%0d %h want 0/0 00007000",
                  io.o_lookup_retry, io.o_lookup_tag, io.o_mem_req_addr);
      end
   endtask

   initial begin
      idle();
      test_reset();
      test_load_miss();
      test_store_merge();
      test_full();
      test_complete_and_rsp_merge();
      test_back_to_back();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
